// File: rtl/irq_controller.sv
// irq_controller: edge-latched, maskable interrupt controller with req/ack/EOI handshake to the CPU.
// Define IRQ_CTRL_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module irq_controller #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_SRC-1:0]  irq_src,
    input  logic [1:0]        dev_addr,
    input  logic [31:0]       dev_wd,
    input  logic              dev_we,
    output logic [31:0]       dev_rd,
    output logic              int_req,
    output logic [ID_W-1:0]   int_id,
    input  logic              int_ack,
    output logic [N_SRC-1:0]  hw_int
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_t;
    state_t           state;
    logic [N_SRC-1:0] src_q, pending, mask, rise, active, clr;
    logic [ID_W-1:0]  winner;
    logic             mask_we, pend_we, eoi_we, unused_wd;

    assign mask_we   = dev_we && dev_addr == 2'd0;
    assign pend_we   = dev_we && dev_addr == 2'd1;
    assign eoi_we    = dev_we && dev_addr == 2'd3;
    assign unused_wd = ^dev_wd[31:N_SRC];
    assign rise      = irq_src & ~src_q;
    assign active    = pending & mask;
    assign hw_int    = active;
    // Software W1C and the ack of the in-request source both clear; a same-cycle rise still wins.
    assign clr = (pend_we ? dev_wd[N_SRC-1:0] : '0) |
                 ((state == REQ && int_ack) ? (N_SRC'(1) << int_id) : '0);
    assign dev_rd = dev_addr == 2'd0 ? 32'(mask) :
                    dev_addr == 2'd1 ? 32'(pending) :
                    dev_addr == 2'd2 ? 32'({state, 1'b0, int_id}) : 32'(int_id);

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_id;

    function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] last, input int k);
        return ID_W'((int'(last) + 1 + k) % N_SRC);
    endfunction

    always_comb begin
        winner = '0;
        for (int k = N_SRC - 1; k >= 0; k--)
            if (active[rr_idx(last_id, k)]) winner = rr_idx(last_id, k);
    end
`else
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (active[i]) winner = ID_W'(i);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src_q   <= '0;
            pending <= '0;
            mask    <= '0;
            int_req <= 1'b0;
            int_id  <= '0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            last_id <= ID_W'(N_SRC - 1);
`endif
        end else begin
            src_q   <= irq_src;
            pending <= (pending & ~clr) | rise;
            if (mask_we) mask <= dev_wd[N_SRC-1:0];
            case (state)
                IDLE: if (|active) begin
                    int_id  <= winner;
                    int_req <= 1'b1;
                    state   <= REQ;
                end
                REQ: if (int_ack) begin
                    int_req <= 1'b0;
                    state   <= SERV;
                end else if (!mask[int_id] || !pending[int_id]) begin
                    int_req <= 1'b0;
                    state   <= IDLE;
                end
                SERV: if (eoi_we) begin
                    state <= IDLE;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
                    last_id <= int_id;
`endif
                end
                default: begin
                    int_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
